// File: rtl/exe_mem_pipe_skid_pkg.sv
// exe_mem_pipe_skid_pkg: shared widths, ctrl bit indices and skid buffer state encoding
package exe_mem_pipe_skid_pkg;
    localparam int DSIZE_DEF = 32;
    localparam int ASIZE_DEF = 5;
    localparam int ISIZE_DEF = 32;
    localparam int CTRL_W = 5;
    localparam int CTRL_WEN = 0;
    localparam int CTRL_MEMREAD = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_JAL = 4;
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t;
    function automatic int payload_w(input int d, input int a, input int i);
        return 2 * d + a + CTRL_W + i;
    endfunction
endpackage

// File: rtl/exe_mem_pipe_skid_buf.sv
// pipe_skid_buf: generic valid/ready stage with flush; SKID=1 adds a second entry and registers in_ready
module pipe_skid_buf
    import exe_mem_pipe_skid_pkg::*;
#(
    parameter int W = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    skid_state_t state, state_nxt;
    logic [W-1:0] skid_q;
    logic ready_q, in_fire, out_fire, load_main, load_skid;

    assign out_valid = state != EMPTY;
    assign in_ready = SKID ? ready_q : (~out_valid | out_ready);
    assign in_fire = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // With SKID=0 the BUSY->FULL arc is unreachable, so one FSM serves both variants
    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        if (flush) state_nxt = EMPTY;
        else case (state)
            EMPTY: begin
                state_nxt = in_fire ? BUSY : EMPTY;
                load_main = in_fire;
            end
            BUSY: begin
                state_nxt = (in_fire & ~out_fire) ? FULL : (~in_fire & out_fire) ? EMPTY : BUSY;
                load_main = in_fire & out_fire;
                load_skid = in_fire & ~out_fire;
            end
            FULL: begin
                state_nxt = out_fire ? BUSY : FULL;
                load_main = out_fire;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            ready_q <= 1'b1;
            out_data <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            ready_q <= state_nxt != FULL;
            if (load_main) out_data <= (state == FULL) ? skid_q : in_data;
            if (load_skid) skid_q <= in_data;
        end
    end
endmodule

// File: rtl/exe_mem_pipe_skid.sv
// exe_mem_pipe_skid: EXE->MEM pipeline register with handshake, flush, bubble-gated ctrl
// and a saturating stall counter
module exe_mem_pipe_skid
    import exe_mem_pipe_skid_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF,
    parameter int ISIZE = ISIZE_DEF,
    parameter bit SKID = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DSIZE-1:0]  aluout_in,
    input  logic [DSIZE-1:0]  rdata2_in,
    input  logic [ASIZE-1:0]  waddr_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [ISIZE-1:0]  pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DSIZE-1:0]  aluout_out,
    output logic [DSIZE-1:0]  rdata2_out,
    output logic [ASIZE-1:0]  waddr_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [ISIZE-1:0]  pc_out,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int PW = payload_w(DSIZE, ASIZE, ISIZE);
    logic [PW-1:0] out_data;
    logic [CTRL_W-1:0] ctrl_q;

    pipe_skid_buf #(.W(PW), .SKID(SKID)) u_buf (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .in_data({aluout_in, rdata2_in, waddr_in, ctrl_in, pc_in}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
    );

    assign {aluout_out, rdata2_out, waddr_out, ctrl_q, pc_out} = out_data;
    // A bubble must never carry wen/memwrite into MEM
    assign ctrl_out = out_valid ? ctrl_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= '0;
        else if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
